fat32_mount_sequencer: RTL and testbench
========================================

# fat32_mount_sequencer

Sequences the FAT32 mount of an SD card. It issues a sector read for the MBR at LBA 0 and captures the partition start LBA. It then reads the partition's boot sector (BPB) and computes the absolute first-data-sector LBA, publishing it with the BPB geometry to downstream file-write logic. It sits between the SD sector-read engine and the file-system block, as the single owner of the read port during mount.

## Interface
- TIMEOUT_CYCLES, 1_000_000, maximum cycles from request to ReadDone before a transfer counts as failed
- RETRY_LIMIT, 3, re-requests allowed per sector before FAIL
- Clock  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- Start  in  1  one-cycle pulse that begins a mount
- ReadRequest  out  1  sector read request, held until ReadAck
- ReadSector  out  32  LBA to read, stable while ReadRequest=1
- ReadAck  in  1  one-cycle acceptance of the request
- ByteValid  in  1  ByteData/ByteIndex valid this cycle
- ByteIndex  in  9  byte offset 0..511 within the sector
- ByteData  in  8  sector byte
- ReadDone  in  1  one-cycle pulse after the last byte
- ReadError  in  1  one-cycle pulse: transfer failed
- PartitionStart  out  32  MBR bytes 0x1C6..0x1C9, little-endian
- ReservedSectors  out  16  BPB 0x0E..0x0F
- NumberOfFAT  out  8  BPB 0x10
- FatLength  out  32  BPB 0x24..0x27
- RootCluster  out  32  BPB 0x2C..0x2F
- RootDirSector  out  32  PartitionStart + ReservedSectors + NumberOfFAT*FatLength
- Busy  out  1  mount in progress
- Mounted  out  1  outputs valid
- Error  out  1  mount failed
- ErrorCode  out  2  0 none, 1 bad MBR signature, 2 bad BPB signature, 3 read failure

## Operation
- States: IDLE, MBR_REQ, MBR_READ, BPB_REQ, BPB_READ, CALC, DONE, FAIL.
- IDLE/DONE/FAIL + Start -> MBR_REQ. This transition clears Mounted, Error, ErrorCode, the retry count and both signature flags. Start is ignored in every other state.
- *_REQ: ReadRequest=1. ReadSector is 0 for the MBR and PartitionStart for the BPB. On ReadAck, go to *_READ.
- *_READ: a byte is captured only when ByteValid=1 and ByteIndex matches a field offset for the current sector. Byte 0x1FE==0x55 and byte 0x1FF==0xAA set the signature flags. ByteValid in any other state is ignored.
- MBR_READ + ReadDone: signature OK -> BPB_REQ; otherwise FAIL with ErrorCode=1.
- BPB_READ + ReadDone: signature OK -> CALC; otherwise FAIL with ErrorCode=2.
- ReadError or timeout in *_REQ/*_READ: retries < RETRY_LIMIT -> back to the same *_REQ, retries+1, field captures for that sector cleared. Otherwise FAIL with ErrorCode=3.
- Retry count resets when MBR_READ completes.
- CALC: one cycle. Registers RootDirSector; product and sum are truncated modulo 2^32. Then DONE.
- DONE: Mounted=1; Busy=0. FAIL: Error=1; Busy=0. Busy=1 in every other non-IDLE state.
- All captured fields hold their values in DONE and FAIL until the next Start.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset mid-transfer drops ReadRequest immediately, and later bytes are ignored.
- ReadRequest rises in the cycle after Start is sampled. It falls in the cycle after ReadAck is sampled.
- BPB ReadRequest rises 1 cycle after MBR ReadDone.
- Mounted rises 2 cycles after BPB ReadDone (CALC, then DONE).
- Timeout counter starts at *_REQ entry and is not reset by ReadAck. Reaching TIMEOUT_CYCLES-1 counts as failure.
- ByteValid at index 0x1FF in the same cycle as ReadDone: the byte is captured and included in the signature check.
- ReadError in the same cycle as ReadDone: the error wins.
- ReadAck and ReadError in the same cycle: the error wins.

## Structure
- Package fat32_pkg:
  - field offsets 0x1C6, 0x0E, 0x10, 0x24, 0x2C, 0x1FE, 0x1FF
  - signature bytes 0x55/0xAA
  - state encoding
  - ErrorCode constants
- Sub-module fat32_field_capture. Parameters: OFFSET and WIDTH_BYTES. It loads a little-endian multi-byte field from the byte stream when enabled, and clears on a clear input. It is instantiated once per captured field.

## Test plan
- Good mount:
  - MBR 0x1C6..0x1C9 = 00 08 00 00 with 55 AA signature.
  - BPB reserved=0x20, NumberOfFAT=2, FatLength=0x3C0, RootCluster=2.
  - Response: second ReadSector=0x800, RootDirSector=0x800+0x20+0x780=0xFA0, Mounted 2 cycles after the last ReadDone.
- MBR byte 0x1FF=0x00 -> FAIL with ErrorCode=1, no BPB request issued.
- ReadError on the BPB read twice, then success -> 3 BPB requests, each with ReadSector=PartitionStart, then Mounted=1.
- No ReadDone with TIMEOUT_CYCLES=100 and RETRY_LIMIT=3 -> 4 MBR requests, then FAIL with ErrorCode=3.
- Overflow:
  - Inputs: FatLength=0xFFFFFFFF, NumberOfFAT=2, PartitionStart=1, reserved=0.
  - Response: RootDirSector=0xFFFFFFFF (wraps modulo 2^32).
- Reset mid-operation and Start while busy:
  - sys_rst_n low during MBR_READ -> all outputs 0 at once.
  - Start pulsed while Busy=1 -> ignored, no extra request.

Source files
------------

// File: rtl/fat32_pkg.sv
// Shared constants, state encoding and geometry arithmetic for the FAT32 mount sequencer.
package fat32_pkg;

  localparam int unsigned OffPartStart = 32'h1C6;
  localparam int unsigned OffReserved  = 32'h00E;
  localparam int unsigned OffNumFat    = 32'h010;
  localparam int unsigned OffFatLength = 32'h024;
  localparam int unsigned OffRootClus  = 32'h02C;

  localparam logic [8:0] OffSig0 = 9'h1FE;
  localparam logic [8:0] OffSig1 = 9'h1FF;

  localparam logic [7:0] SigByte0 = 8'h55;
  localparam logic [7:0] SigByte1 = 8'hAA;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrMbrSig   = 2'd1;
  localparam logic [1:0] ErrBpbSig   = 2'd2;
  localparam logic [1:0] ErrReadFail = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StMbrReq,
    StMbrRead,
    StBpbReq,
    StBpbRead,
    StCalc,
    StDone,
    StFail
  } fat32_state_e;

  // Product and sum deliberately wrap modulo 2^32.
  function automatic logic [31:0] root_dir_sector(input logic [31:0] part_start,
                                                  input logic [15:0] reserved,
                                                  input logic [7:0]  num_fat,
                                                  input logic [31:0] fat_length);
    return part_start + 32'(reserved) + 32'(num_fat) * fat_length;
  endfunction

endpackage

// File: rtl/fat32_field_capture.sv
// Captures a little-endian multi-byte field from an indexed sector byte stream.
module fat32_field_capture #(
  parameter int unsigned OFFSET      = 0,
  parameter int unsigned WIDTH_BYTES = 4
) (
  input  logic                     Clock,
  input  logic                     sys_rst_n,
  input  logic                     i_enable,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [8:0]               i_index,
  input  logic [7:0]               i_data,
  output logic [8*WIDTH_BYTES-1:0] o_field
);

  logic [8*WIDTH_BYTES-1:0] r_field;

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_field <= '0;
    end else if (i_clear) begin
      r_field <= '0;
    end else if (i_enable && i_valid) begin
      for (int unsigned b = 0; b < WIDTH_BYTES; b++) begin
        if (i_index == 9'(OFFSET + b)) r_field[8*b +: 8] <= i_data;
      end
    end
  end

  assign o_field = r_field;

endmodule

// File: rtl/fat32_mount_sequencer.sv
// Reads the MBR then the partition boot sector and publishes FAT32 geometry plus the
// absolute root-directory LBA.
module fat32_mount_sequencer
  import fat32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic        Clock,
  input  logic        sys_rst_n,
  input  logic        Start,
  output logic        ReadRequest,
  output logic [31:0] ReadSector,
  input  logic        ReadAck,
  input  logic        ByteValid,
  input  logic [8:0]  ByteIndex,
  input  logic [7:0]  ByteData,
  input  logic        ReadDone,
  input  logic        ReadError,
  output logic [31:0] PartitionStart,
  output logic [15:0] ReservedSectors,
  output logic [7:0]  NumberOfFAT,
  output logic [31:0] FatLength,
  output logic [31:0] RootCluster,
  output logic [31:0] RootDirSector,
  output logic        Busy,
  output logic        Mounted,
  output logic        Error,
  output logic [1:0]  ErrorCode
);

  localparam int unsigned TimerW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RetryW = ($clog2(RETRY_LIMIT + 1) > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  fat32_state_e      r_state, w_state_next;
  logic [TimerW-1:0] r_timer;
  logic [RetryW-1:0] r_retries;
  logic              r_sig0, r_sig1;
  logic [1:0]        r_err_code;
  logic [31:0]       r_root_dir;

  logic w_start, w_req_entry, w_clr_mbr, w_clr_bpb;
  logic w_retry_inc, w_retry_clr, w_set_err, w_calc;
  logic [1:0] w_err_val;
  logic w_mbr_read, w_bpb_read, w_active, w_in_read;
  logic w_byte_sig0, w_byte_sig1, w_sig_ok, w_xfer_fail, w_can_retry;

  assign w_mbr_read = (r_state == StMbrRead);
  assign w_bpb_read = (r_state == StBpbRead);
  assign w_in_read  = w_mbr_read || w_bpb_read;
  assign w_active   = w_in_read || (r_state == StMbrReq) || (r_state == StBpbReq);

  // Signature bytes arriving alongside ReadDone still count toward the check.
  assign w_byte_sig0 = ByteValid && (ByteIndex == OffSig0) && (ByteData == SigByte0);
  assign w_byte_sig1 = ByteValid && (ByteIndex == OffSig1) && (ByteData == SigByte1);
  assign w_sig_ok    = (r_sig0 || w_byte_sig0) && (r_sig1 || w_byte_sig1);

  assign w_xfer_fail = ReadError || (r_timer == TimerMax);
  assign w_can_retry = (32'(r_retries) < RETRY_LIMIT);

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_req_entry  = 1'b0;
    w_clr_mbr    = 1'b0;
    w_clr_bpb    = 1'b0;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_set_err    = 1'b0;
    w_err_val    = ErrNone;
    w_calc       = 1'b0;
    unique case (r_state)
      StIdle, StDone, StFail: begin
        if (Start) begin
          w_state_next = StMbrReq;
          w_start      = 1'b1;
          w_req_entry  = 1'b1;
          w_clr_mbr    = 1'b1;
          w_clr_bpb    = 1'b1;
        end
      end
      StMbrReq, StMbrRead: begin
        if (w_xfer_fail) begin
          if (w_can_retry) begin
            w_state_next = StMbrReq;
            w_req_entry  = 1'b1;
            w_retry_inc  = 1'b1;
            w_clr_mbr    = 1'b1;
          end else begin
            w_state_next = StFail;
            w_set_err    = 1'b1;
            w_err_val    = ErrReadFail;
          end
        end else if (r_state == StMbrReq) begin
          if (ReadAck) w_state_next = StMbrRead;
        end else if (ReadDone) begin
          w_retry_clr = 1'b1;
          if (w_sig_ok) begin
            w_state_next = StBpbReq;
            w_req_entry  = 1'b1;
          end else begin
            w_state_next = StFail;
            w_set_err    = 1'b1;
            w_err_val    = ErrMbrSig;
          end
        end
      end
      StBpbReq, StBpbRead: begin
        if (w_xfer_fail) begin
          if (w_can_retry) begin
            w_state_next = StBpbReq;
            w_req_entry  = 1'b1;
            w_retry_inc  = 1'b1;
            w_clr_bpb    = 1'b1;
          end else begin
            w_state_next = StFail;
            w_set_err    = 1'b1;
            w_err_val    = ErrReadFail;
          end
        end else if (r_state == StBpbReq) begin
          if (ReadAck) w_state_next = StBpbRead;
        end else if (ReadDone) begin
          if (w_sig_ok) begin
            w_state_next = StCalc;
          end else begin
            w_state_next = StFail;
            w_set_err    = 1'b1;
            w_err_val    = ErrBpbSig;
          end
        end
      end
      StCalc: begin
        w_calc       = 1'b1;
        w_state_next = StDone;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_timer    <= '0;
      r_retries  <= '0;
      r_sig0     <= 1'b0;
      r_sig1     <= 1'b0;
      r_err_code <= ErrNone;
      r_root_dir <= '0;
    end else begin
      // Timer runs from request entry through the data phase; ReadAck does not restart it.
      if (w_req_entry)   r_timer <= '0;
      else if (w_active) r_timer <= r_timer + TimerW'(1);

      if (w_start || w_retry_clr) r_retries <= '0;
      else if (w_retry_inc)       r_retries <= r_retries + RetryW'(1);

      if (w_req_entry) begin
        r_sig0 <= 1'b0;
        r_sig1 <= 1'b0;
      end else if (w_in_read) begin
        if (w_byte_sig0) r_sig0 <= 1'b1;
        if (w_byte_sig1) r_sig1 <= 1'b1;
      end

      if (w_start)        r_err_code <= ErrNone;
      else if (w_set_err) r_err_code <= w_err_val;

      if (w_start)     r_root_dir <= '0;
      else if (w_calc) r_root_dir <= root_dir_sector(PartitionStart, ReservedSectors,
                                                     NumberOfFAT, FatLength);
    end
  end

  fat32_field_capture #(.OFFSET(OffPartStart), .WIDTH_BYTES(4)) u_part_start (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .i_enable(w_mbr_read), .i_clear(w_clr_mbr),
    .i_valid(ByteValid), .i_index(ByteIndex), .i_data(ByteData), .o_field(PartitionStart)
  );

  fat32_field_capture #(.OFFSET(OffReserved), .WIDTH_BYTES(2)) u_reserved (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .i_enable(w_bpb_read), .i_clear(w_clr_bpb),
    .i_valid(ByteValid), .i_index(ByteIndex), .i_data(ByteData), .o_field(ReservedSectors)
  );

  fat32_field_capture #(.OFFSET(OffNumFat), .WIDTH_BYTES(1)) u_num_fat (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .i_enable(w_bpb_read), .i_clear(w_clr_bpb),
    .i_valid(ByteValid), .i_index(ByteIndex), .i_data(ByteData), .o_field(NumberOfFAT)
  );

  fat32_field_capture #(.OFFSET(OffFatLength), .WIDTH_BYTES(4)) u_fat_length (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .i_enable(w_bpb_read), .i_clear(w_clr_bpb),
    .i_valid(ByteValid), .i_index(ByteIndex), .i_data(ByteData), .o_field(FatLength)
  );

  fat32_field_capture #(.OFFSET(OffRootClus), .WIDTH_BYTES(4)) u_root_cluster (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .i_enable(w_bpb_read), .i_clear(w_clr_bpb),
    .i_valid(ByteValid), .i_index(ByteIndex), .i_data(ByteData), .o_field(RootCluster)
  );

  assign ReadRequest   = (r_state == StMbrReq) || (r_state == StBpbReq);
  assign ReadSector    = (r_state == StBpbReq) ? PartitionStart : 32'h0;
  assign RootDirSector = r_root_dir;
  assign Busy          = !((r_state == StIdle) || (r_state == StDone) || (r_state == StFail));
  assign Mounted       = (r_state == StDone);
  assign Error         = (r_state == StFail);
  assign ErrorCode     = r_err_code;

endmodule

// File: tb/tb_fat32_mount_sequencer.sv
// Randomized mount scenarios checked against a sector-level behavioural model.
module tb_fat32_mount_sequencer;

  localparam int unsigned Timeout = 100;
  localparam int unsigned Retries = 3;

  logic        Clock = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        ReadAck = 1'b0;
  logic        ByteValid = 1'b0;
  logic [8:0]  ByteIndex = '0;
  logic [7:0]  ByteData = '0;
  logic        ReadDone = 1'b0;
  logic        ReadError = 1'b0;
  logic        ReadRequest, Busy, Mounted, Error;
  logic [31:0] ReadSector, PartitionStart, FatLength, RootCluster, RootDirSector;
  logic [15:0] ReservedSectors;
  logic [7:0]  NumberOfFAT;
  logic [1:0]  ErrorCode;

  always #5 Clock = ~Clock;

  fat32_mount_sequencer #(.TIMEOUT_CYCLES(Timeout), .RETRY_LIMIT(Retries)) dut (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .Start(Start),
    .ReadRequest(ReadRequest), .ReadSector(ReadSector), .ReadAck(ReadAck),
    .ByteValid(ByteValid), .ByteIndex(ByteIndex), .ByteData(ByteData),
    .ReadDone(ReadDone), .ReadError(ReadError),
    .PartitionStart(PartitionStart), .ReservedSectors(ReservedSectors),
    .NumberOfFAT(NumberOfFAT), .FatLength(FatLength), .RootCluster(RootCluster),
    .RootDirSector(RootDirSector), .Busy(Busy), .Mounted(Mounted), .Error(Error),
    .ErrorCode(ErrorCode)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Actions per request: 0 good, 1 bytes then ReadDone+ReadError, 2 silence, 3 ReadAck+ReadError
  typedef struct {
    logic [31:0] lba;
    int          kind;
    int          act;
  } req_t;

  logic [7:0]  mbr_img [512];
  logic [7:0]  bpb_img [512];
  int          act_q[$];
  req_t        exp_reqs[$];
  logic        exp_mounted, exp_error;
  logic [1:0]  exp_code;
  logic [31:0] exp_part, exp_fatlen, exp_rclus, exp_root;
  logic [15:0] exp_rsvd;
  logic [7:0]  exp_nfat;

  int unsigned offs [16] = '{'h1C6, 'h1C7, 'h1C8, 'h1C9, 'h0E, 'h0F, 'h10, 'h24,
                             'h25, 'h26, 'h27, 'h2C, 'h2D, 'h2E, 'h2F, 'h1FE};

  task automatic model_capture(input int kind);
    if (kind == 0) begin
      exp_part = {mbr_img['h1C9], mbr_img['h1C8], mbr_img['h1C7], mbr_img['h1C6]};
    end else begin
      exp_rsvd   = {bpb_img['h0F], bpb_img['h0E]};
      exp_nfat   = bpb_img['h10];
      exp_fatlen = {bpb_img['h27], bpb_img['h26], bpb_img['h25], bpb_img['h24]};
      exp_rclus  = {bpb_img['h2F], bpb_img['h2E], bpb_img['h2D], bpb_img['h2C]};
    end
  endtask

  task automatic model_clear(input int kind);
    if (kind == 0) begin
      exp_part = '0;
    end else begin
      exp_rsvd = '0; exp_nfat = '0; exp_fatlen = '0; exp_rclus = '0;
    end
  endtask

  task automatic model_mount();
    int kind, tries, act;
    bit sig;
    req_t r;
    longint unsigned a, b, c, d;
    kind = 0; tries = 0;
    exp_reqs.delete();
    exp_mounted = 1'b0; exp_error = 1'b0; exp_code = 2'd0; exp_root = '0;
    model_clear(0);
    model_clear(1);
    forever begin
      act = (act_q.size() > 0) ? act_q.pop_front() : 0;
      r.lba = (kind == 0) ? 32'h0 : exp_part;
      r.kind = kind;
      r.act = act;
      exp_reqs.push_back(r);
      if (act <= 1) model_capture(kind);
      if (act == 0) begin
        sig = (kind == 0) ? (mbr_img[510] == 8'h55 && mbr_img[511] == 8'hAA)
                          : (bpb_img[510] == 8'h55 && bpb_img[511] == 8'hAA);
        if (!sig) begin
          exp_error = 1'b1; exp_code = 2'(kind + 1);
          return;
        end
        if (kind == 0) begin
          kind = 1; tries = 0;
        end else begin
          a = exp_part; b = exp_rsvd; c = exp_nfat; d = exp_fatlen;
          exp_root = 32'((a + b + c * d) % 64'h1_0000_0000);
          exp_mounted = 1'b1;
          return;
        end
      end else if (tries < int'(Retries)) begin
        tries++;
        model_clear(kind);
      end else begin
        exp_error = 1'b1; exp_code = 2'd3;
        return;
      end
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    ByteValid = 1'b0; ReadAck = 1'b0; ReadDone = 1'b0; ReadError = 1'b0; Start = 1'b0;
  endtask

  task automatic drive_byte(input int kind, input int idx, input bit force_sig);
    logic [7:0] d;
    d = (kind == 0) ? mbr_img[idx] : bpb_img[idx];
    if (force_sig && idx == 'h1FE) d = 8'h55;
    if (force_sig && idx == 'h1FF) d = 8'hAA;
    ByteValid = 1'b1; ByteIndex = 9'(idx); ByteData = d;
  endtask

  task automatic drive_junk();
    ByteValid = 1'($urandom_range(1));
    ByteIndex = 9'(offs[$urandom_range(15)]);
    ByteData  = 8'($urandom);
  endtask

  task automatic serve(input req_t r, output bit ok);
    int n;
    int q[$];
    ok = 1'b1;
    n = 0;
    while (ReadRequest !== 1'b1 && n < 400) begin tick(); n++; end
    if (ReadRequest !== 1'b1) begin
      check_eq("req_seen", 64'(ReadRequest), 64'(1));
      ok = 1'b0;
      return;
    end
    check_eq("read_sector", 64'(ReadSector), 64'(r.lba));
    repeat ($urandom_range(3)) begin drive_junk(); tick(); end
    drive_junk();
    ReadAck = 1'b1; ReadError = (r.act == 3);
    tick();
    idle_inputs();
    if (r.act == 3) return;
    check_eq("req_drop", 64'(ReadRequest), 64'(0));
    if (r.act == 2) return;
    foreach (offs[k]) q.push_back(int'(offs[k]));
    repeat (4) q.push_back(int'($urandom_range(509)));
    for (int k = q.size() - 1; k > 0; k--) begin
      int j, t;
      j = int'($urandom_range(k));
      t = q[k]; q[k] = q[j]; q[j] = t;
    end
    foreach (q[k]) begin
      drive_byte(r.kind, q[k], r.act == 1);
      Start = ($urandom_range(15) == 0);
      tick();
      ByteValid = 1'b0; Start = 1'b0;
      if ($urandom_range(1) == 1) tick();
    end
    drive_byte(r.kind, 'h1FF, r.act == 1);
    if ($urandom_range(1) == 1) begin tick(); ByteValid = 1'b0; end
    ReadDone = 1'b1; ReadError = (r.act == 1);
    tick();
    idle_inputs();
  endtask

  task automatic run_scenario(input string name);
    bit ok;
    int n, extra, last;
    model_mount();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_eq({name, "_start_lat"}, 64'(ReadRequest), 64'(1));
    last = exp_reqs.size() - 1;
    foreach (exp_reqs[i]) begin
      serve(exp_reqs[i], ok);
      if (!ok) break;
      if (exp_reqs[i].act == 0 && i == last && exp_mounted) begin
        check_eq({name, "_calc_cycle"}, 64'({Mounted, Busy}), 64'(2'b01));
        tick();
        check_eq({name, "_mounted_lat"}, 64'(Mounted), 64'(1));
      end else if (exp_reqs[i].act == 0 && exp_reqs[i].kind == 0 && i < last) begin
        check_eq({name, "_bpb_req_lat"}, 64'(ReadRequest), 64'(1));
      end
    end
    n = 0; extra = 0;
    while (Busy === 1'b1 && n < 400) begin
      if (ReadRequest === 1'b1) extra++;
      tick(); n++;
    end
    check_eq({name, "_busy_end"}, 64'(Busy), 64'(0));
    check_eq({name, "_extra_req"}, 64'(extra), 64'(0));
    check_eq({name, "_mounted"}, 64'(Mounted), 64'(exp_mounted));
    check_eq({name, "_error"}, 64'({Error, ErrorCode}), 64'({exp_error, exp_code}));
    check_eq({name, "_part"}, 64'(PartitionStart), 64'(exp_part));
    check_eq({name, "_geom"}, {ReservedSectors, NumberOfFAT, 8'h0, FatLength},
             {exp_rsvd, exp_nfat, 8'h0, exp_fatlen});
    check_eq({name, "_rclus"}, 64'(RootCluster), 64'(exp_rclus));
    check_eq({name, "_root"}, 64'(RootDirSector), 64'(exp_root));
  endtask

  task automatic random_images();
    for (int i = 0; i < 512; i++) begin
      mbr_img[i] = 8'($urandom);
      bpb_img[i] = 8'($urandom);
    end
    if ($urandom_range(7) != 0) begin mbr_img[510] = 8'h55; mbr_img[511] = 8'hAA; end
    if ($urandom_range(7) != 0) begin bpb_img[510] = 8'h55; bpb_img[511] = 8'hAA; end
  endtask

  task automatic plan_images();
    random_images();
    mbr_img['h1C6] = 8'h00; mbr_img['h1C7] = 8'h08; mbr_img['h1C8] = 8'h00;
    mbr_img['h1C9] = 8'h00; mbr_img[510] = 8'h55; mbr_img[511] = 8'hAA;
    bpb_img['h0E] = 8'h20; bpb_img['h0F] = 8'h00; bpb_img['h10] = 8'h02;
    bpb_img['h24] = 8'hC0; bpb_img['h25] = 8'h03; bpb_img['h26] = 8'h00; bpb_img['h27] = 8'h00;
    bpb_img['h2C] = 8'h02; bpb_img['h2D] = 8'h00; bpb_img['h2E] = 8'h00; bpb_img['h2F] = 8'h00;
    bpb_img[510] = 8'h55; bpb_img[511] = 8'hAA;
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_ctrl"}, 64'({ReadRequest, Busy, Mounted, Error, ErrorCode}), 64'(0));
    check_eq({name, "_sector"}, 64'(ReadSector), 64'(0));
    check_eq({name, "_part"}, 64'(PartitionStart), 64'(0));
    check_eq({name, "_geom"}, {ReservedSectors, NumberOfFAT, 8'h0, FatLength}, 64'(0));
    check_eq({name, "_clus_root"}, {RootCluster, RootDirSector}, 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    tick();

    plan_images();
    run_scenario("good");
    check_eq("plan_root", 64'(RootDirSector), 64'(32'hFA0));

    plan_images();
    mbr_img[511] = 8'h00;
    run_scenario("bad_mbr_sig");
    check_eq("plan_mbr_code", 64'(ErrorCode), 64'(1));

    plan_images();
    act_q = '{0, 1, 3};
    run_scenario("bpb_retry");
    check_eq("plan_retry_mounted", 64'(Mounted), 64'(1));

    plan_images();
    act_q = '{2, 2, 2, 2};
    run_scenario("timeout");
    check_eq("plan_timeout_code", 64'(ErrorCode), 64'(3));

    plan_images();
    mbr_img['h1C6] = 8'h01; mbr_img['h1C7] = 8'h00; mbr_img['h1C8] = 8'h00;
    mbr_img['h1C9] = 8'h00;
    bpb_img['h0E] = 8'h00; bpb_img['h0F] = 8'h00; bpb_img['h10] = 8'h02;
    bpb_img['h24] = 8'hFF; bpb_img['h25] = 8'hFF; bpb_img['h26] = 8'hFF; bpb_img['h27] = 8'hFF;
    run_scenario("overflow");
    check_eq("plan_overflow_root", 64'(RootDirSector), 64'(32'hFFFF_FFFF));

    // Reset while the MBR data phase is under way.
    plan_images();
    mbr_img['h1C6] = 8'h5A;
    Start = 1'b1; tick(); Start = 1'b0;
    ReadAck = 1'b1; tick(); ReadAck = 1'b0;
    drive_byte(0, 'h1C6, 1'b0); tick(); ByteValid = 1'b0;
    check_eq("pre_rst_part", 64'(PartitionStart), 64'(32'h5A));
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    tick();
    sys_rst_n = 1'b1;
    drive_byte(0, 'h1C6, 1'b0); tick();
    drive_byte(0, 'h1FF, 1'b0); ReadDone = 1'b1; tick();
    idle_inputs();
    tick();
    check_all_zero("post_rst");

    for (int s = 0; s < 30; s++) begin
      random_images();
      act_q.delete();
      repeat ($urandom_range(5)) begin
        int w;
        w = int'($urandom_range(9));
        act_q.push_back((w < 5) ? 0 : (w < 7) ? 1 : (w < 8) ? 2 : 3);
      end
      run_scenario($sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
